// File: rtl/int_to_float.sv
`default_nettype none
// ============================================================================
//  Module   : int_to_float
//  Function : 32-bit signed integer to IEEE-754 single, round-to-nearest-even,
//             strobe/ack handshake on both sides; one conversion in flight.
//  Revision : 1.0
// ============================================================================
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    S_GET_A     = 3'd0,
    S_CONVERT_0 = 3'd1,
    S_CONVERT_1 = 3'd2,
    S_CONVERT_2 = 3'd3,
    S_ROUND     = 3'd4,
    S_PACK      = 3'd5,
    S_PUT_Z     = 3'd6
  } state_t;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_value;
  logic [31:0] r_z;
  logic [23:0] r_z_m;
  logic [7:0]  r_z_e;
  logic        r_z_s;
  logic        r_guard;
  logic        r_round_bit;
  logic        r_sticky;
  logic        r_input_a_ack;
  logic        r_output_z_stb;
  logic [31:0] r_output_z;

  logic [31:0] w_mag;
  logic        w_round_up;
  logic [7:0]  w_exp_biased;

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign w_mag        = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_round_up   = r_guard && (r_round_bit || r_sticky || r_z_m[0]);
  assign w_exp_biased = r_z_e + 8'd127;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_GET_A;
      r_input_a_ack  <= 1'b0;
      r_output_z_stb <= 1'b0;
      r_output_z     <= 32'd0;
    end else begin
      case (r_state)
        S_GET_A: begin
          r_input_a_ack <= 1'b1;
          if (r_input_a_ack && input_a_stb) begin
            r_a           <= input_a;
            r_input_a_ack <= 1'b0;
            r_state       <= S_CONVERT_0;
          end
        end
        S_CONVERT_0: begin
          if (r_a == 32'd0) begin
            r_z     <= 32'd0;
            r_state <= S_PACK;
          end else begin
            r_z_s   <= r_a[31];
            r_value <= w_mag;
            r_z_e   <= 8'd31;
            r_state <= S_CONVERT_1;
          end
        end
        S_CONVERT_1: begin
          if (!r_value[31]) begin
            r_value <= {r_value[30:0], 1'b0};
            r_z_e   <= r_z_e - 8'd1;
          end else begin
            r_state <= S_CONVERT_2;
          end
        end
        S_CONVERT_2: begin
          r_z_m       <= r_value[31:8];
          r_guard     <= r_value[7];
          r_round_bit <= r_value[6];
          r_sticky    <= |r_value[5:0];
          r_state     <= S_ROUND;
        end
        S_ROUND: begin
          // A mantissa carry-out wraps to zero; bumping the exponent completes it.
          if (w_round_up) begin
            r_z_m <= r_z_m + 24'd1;
            if (r_z_m == 24'hffffff) begin
              r_z_e <= r_z_e + 8'd1;
            end
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          if (r_a != 32'd0) begin
            r_z <= {r_z_s, w_exp_biased, r_z_m[22:0]};
          end
          r_state <= S_PUT_Z;
        end
        S_PUT_Z: begin
          r_output_z_stb <= 1'b1;
          r_output_z     <= r_z;
          if (r_output_z_stb && output_z_ack) begin
            r_output_z_stb <= 1'b0;
            r_state        <= S_GET_A;
          end
        end
        default: begin
          r_state <= S_GET_A;
        end
      endcase
    end
  end

  assign input_a_ack  = r_input_a_ack;
  assign output_z_stb = r_output_z_stb;
  assign output_z     = r_output_z;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_to_float
//  Function : Self-checking bench for int_to_float (vector table, scoreboard).
//  Revision : 1.0
// ============================================================================
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  int_to_float dut (
    .clk         (clk),
    .rst         (rst),
    .input_a     (input_a),
    .input_a_stb (input_a_stb),
    .input_a_ack (input_a_ack),
    .output_z    (output_z),
    .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int msb_pos(input logic [31:0] m);
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] a);
    return a[31] ? (32'd0 - a) : a;
  endfunction

  // Reference: locate the MSB, keep 24 significant bits, resolve ties to even.
  function automatic logic [31:0] ref_i2f(input logic [31:0] a);
    logic [63:0] m, q, rem, half;
    logic [7:0]  e;
    int          p, sh;
    if (a == 32'd0) return 32'd0;
    m = {32'd0, mag(a)};
    p = msb_pos(m[31:0]);
    e = 8'(p + 127);
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 8'd1;
      end
    end
    return {a[31], e, q[22:0]};
  endfunction

  task automatic convert(input logic [31:0] a, input logic [31:0] z, input int lat, input int hold);
    int          n;
    logic [31:0] want;
    @(negedge clk);
    n = 0;
    while (input_a_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("input_ready", {31'd0, input_a_ack}, 32'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    exp_q.push_back(z);
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
    check("ack_drop_on_capture", {31'd0, input_a_ack}, 32'd0);
    n = 0;
    while (output_z_stb !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    want = exp_q.pop_front();
    check("output_z", output_z, want);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_stb", {31'd0, output_z_stb}, 32'd1);
      check("hold_z", output_z, want);
      check("hold_in_ack", {31'd0, input_a_ack}, 32'd0);
    end
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    check("stb_drop_after_ack", {31'd0, output_z_stb}, 32'd0);
    if (hold > 0) check("in_ack_low_at_ack_edge", {31'd0, input_a_ack}, 32'd0);
    @(posedge clk);
    #1;
    check("in_ack_after_ack", {31'd0, input_a_ack}, 32'd1);
  endtask

  initial begin
    logic [31:0] ra;

    vecs[0]  = '{32'h00000001, 32'h3F800000, 37};
    vecs[1]  = '{32'hFFFFFFFF, 32'hBF800000, 37};
    vecs[2]  = '{32'h80000000, 32'hCF000000, 6};
    vecs[3]  = '{32'h00000000, 32'h00000000, 3};
    vecs[4]  = '{32'h01000001, 32'h4B800000, 13};
    vecs[5]  = '{32'h01000003, 32'h4B800002, 13};
    vecs[6]  = '{32'h7FFFFFFF, 32'h4F000000, 7};
    vecs[7]  = '{32'h00000002, 32'h40000000, 36};
    vecs[8]  = '{32'h00000007, 32'h40E00000, 35};
    vecs[9]  = '{32'hFFFFFF9C, 32'hC2C80000, 31};
    vecs[10] = '{32'h00FFFFFF, 32'h4B7FFFFF, 14};
    vecs[11] = '{32'h01000002, 32'h4B800001, 13};
    vecs[12] = '{32'h01000005, 32'h4B800002, 13};

    rst          = 1'b1;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_stb", {31'd0, output_z_stb}, 32'd0);
    check("reset_in_ack", {31'd0, input_a_ack}, 32'd0);
    check("reset_z", output_z, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      convert(vecs[i].a, vecs[i].z, vecs[i].lat, 0);
    end

    // Backpressure: result held for ten cycles before the consumer takes it.
    convert(32'h00000064, 32'h42C80000, 31, 10);

    // Reset while normalising an operand of 1, then a clean conversion of 2.
    @(negedge clk);
    input_a     = 32'h00000001;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_stb", {31'd0, output_z_stb}, 32'd0);
    check("abort_in_ack", {31'd0, input_a_ack}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_in_ack_return", {31'd0, input_a_ack}, 32'd1);
    convert(32'h00000002, 32'h40000000, 36, 0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = 32'd0 - ra;
      if (ra == 32'd0) ra = 32'd5;
      convert(ra, ref_i2f(ra), 37 - msb_pos(mag(ra)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
